// File: rtl/ram_pkg.sv
// Shared constants and elaboration-time configuration checks for the
// RAM-based synchronous FIFO.
package ram_pkg;

   localparam string REGMODE_NOREG = "noreg";
   localparam string REGMODE_REG   = "reg";

   // Thresholds must be ordered and lie inside 0..depth.
   function automatic bit fifo_cfg_ok(input int addr_width, input int ae_th, input int af_th);
      int depth;
      bit ok;
      ok = 1'b0;
      if ((addr_width >= 32'sd1) && (addr_width <= 32'sd30)) begin
         depth = 32'sd1 << addr_width;
         ok    = (ae_th >= 32'sd0) && (ae_th < af_th) && (af_th <= depth);
      end else begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one synchronous read port with
// a resettable output register, inferable as block or distributed RAM.
module fifo_sdp_ram #(
   parameter int DW = 18,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_data_d;
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-before-write: a same-address read and write (FIFO full) returns old data.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_fifo_sc.sv
// Single-clock FIFO over a simple dual-port RAM: pointers, count, registered
// status flags, overflow/underflow pulses and an optional output register.
module ram_fifo_sc
   import ram_pkg::*;
#(
   parameter int    pmi_data_width      = 18,
   parameter int    pmi_addr_width      = 9,
   parameter string pmi_regmode         = "noreg",
   parameter int    pmi_almost_full_th  = (32'sd1 << pmi_addr_width) - 32'sd4,
   parameter int    pmi_almost_empty_th = 32'sd4
) (
   input  logic                      Clock,
   input  logic                      ResetN,
   input  logic [pmi_data_width-1:0] Data,
   input  logic                      WrEn,
   input  logic                      RdEn,
   output logic [pmi_data_width-1:0] Q,
   output logic                      QValid,
   output logic                      Empty,
   output logic                      Full,
   output logic                      AlmostEmpty,
   output logic                      AlmostFull,
   output logic [pmi_addr_width:0]   Count,
   output logic                      Overflow,
   output logic                      Underflow
);

   localparam int DW = pmi_data_width;
   localparam int AW = pmi_addr_width;
   localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AF_C    = (AW+1)'(pmi_almost_full_th);
   localparam logic [AW:0] AE_C    = (AW+1)'(pmi_almost_empty_th);
   localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam bit USE_OUTREG = (pmi_regmode == REGMODE_REG);
   localparam bit CFG_OK = fifo_cfg_ok(pmi_addr_width, pmi_almost_empty_th, pmi_almost_full_th)
                           && ((pmi_regmode == REGMODE_NOREG) || (pmi_regmode == REGMODE_REG));

   if (!CFG_OK) begin : g_cfg_err
      $error("ram_fifo_sc: invalid depth, threshold or regmode configuration");
   end

   logic          rd_acc_s;
   logic          wr_acc_s;
   logic [AW:0]   wr_ptr_d, wr_ptr_q;
   logic [AW:0]   rd_ptr_d, rd_ptr_q;
   logic [AW:0]   count_d, count_q;
   logic          empty_d, empty_q;
   logic          full_d, full_q;
   logic          aempty_d, aempty_q;
   logic          afull_d, afull_q;
   logic          ovf_d, ovf_q;
   logic          unf_d, unf_q;
   logic          rd_vld_d, rd_vld_q;
   logic [DW-1:0] ram_rd_data_s;

   // Pointers carry an extra wrap bit, so their difference spans 0..depth.
   always_comb begin
      rd_acc_s = RdEn & ~empty_q;
      wr_acc_s = WrEn & (~full_q | rd_acc_s);
      if (wr_acc_s) begin
         wr_ptr_d = wr_ptr_q + ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
         rd_ptr_d = rd_ptr_q + ONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d  = wr_ptr_d - rd_ptr_d;
      empty_d  = (count_d == '0);
      full_d   = (count_d == DEPTH_C);
      aempty_d = (count_d <= AE_C);
      afull_d  = (count_d >= AF_C);
      ovf_d    = WrEn & ~wr_acc_s;
      unf_d    = RdEn & ~rd_acc_s;
      rd_vld_d = rd_acc_s;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   fifo_sdp_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk     (Clock),
      .rst_n   (ResetN),
      .wr_en   (wr_acc_s),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (Data),
      .rd_en   (rd_acc_s),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (ram_rd_data_s)
   );

   if (USE_OUTREG) begin : g_outreg
      logic [DW-1:0] q_d, q_q;
      logic          qv_d, qv_q;

      // Extra stage re-captures the RAM word only when a fresh one arrived.
      always_comb begin
         qv_d = rd_vld_q;
         if (rd_vld_q) begin
            q_d = ram_rd_data_s;
         end else begin
            q_d = q_q;
         end
      end

      always_ff @(posedge Clock or negedge ResetN) begin
         if (!ResetN) begin
            q_q  <= '0;
            qv_q <= 1'b0;
         end else begin
            q_q  <= q_d;
            qv_q <= qv_d;
         end
      end

      assign Q      = q_q;
      assign QValid = qv_q;
   end else begin : g_noreg
      assign Q      = ram_rd_data_s;
      assign QValid = rd_vld_q;
   end

   assign Empty       = empty_q;
   assign Full        = full_q;
   assign AlmostEmpty = aempty_q;
   assign AlmostFull  = afull_q;
   assign Count       = count_q;
   assign Overflow    = ovf_q;
   assign Underflow   = unf_q;

endmodule

// File: tb/tb_ram_fifo_sc.sv
// Bench driving a "noreg" and a "reg" FIFO (8 bits x 16) with identical
// stimulus, checked every cycle against a queue-based reference model.
module tb_ram_fifo_sc;

   localparam int DEPTH = 16;
   localparam int AF_TH = 12;
   localparam int AE_TH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       wr, rd;

   logic [7:0] q_n, q_r;
   logic       qv_n, qv_r, emp_n, emp_r, ful_n, ful_r;
   logic       ae_n, ae_r, af_n, af_r, ovf_n, ovf_r, unf_n, unf_r;
   logic [4:0] cnt_n, cnt_r;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] fq[$];
   logic [7:0] e_qn, e_qr, pend_d;
   logic       e_qvn, e_qvr, pend_v, e_ovf, e_unf;

   always #5 clk = ~clk;

   ram_fifo_sc #(.pmi_data_width(8), .pmi_addr_width(4), .pmi_regmode("noreg")) dut_n (
      .Clock(clk), .ResetN(rst_n), .Data(data), .WrEn(wr), .RdEn(rd),
      .Q(q_n), .QValid(qv_n), .Empty(emp_n), .Full(ful_n),
      .AlmostEmpty(ae_n), .AlmostFull(af_n), .Count(cnt_n),
      .Overflow(ovf_n), .Underflow(unf_n));

   ram_fifo_sc #(.pmi_data_width(8), .pmi_addr_width(4), .pmi_regmode("reg")) dut_r (
      .Clock(clk), .ResetN(rst_n), .Data(data), .WrEn(wr), .RdEn(rd),
      .Q(q_r), .QValid(qv_r), .Empty(emp_r), .Full(ful_r),
      .AlmostEmpty(ae_r), .AlmostFull(af_r), .Count(cnt_r),
      .Overflow(ovf_r), .Underflow(unf_r));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int c;
      c = fq.size();
      chk({tag, ":count_n"}, 32'(cnt_n), 32'(c));
      chk({tag, ":count_r"}, 32'(cnt_r), 32'(c));
      chk({tag, ":empty_n"}, 32'(emp_n), 32'(c == 0));
      chk({tag, ":empty_r"}, 32'(emp_r), 32'(c == 0));
      chk({tag, ":full_n"},  32'(ful_n), 32'(c == DEPTH));
      chk({tag, ":full_r"},  32'(ful_r), 32'(c == DEPTH));
      chk({tag, ":aempty_n"}, 32'(ae_n), 32'(c <= AE_TH));
      chk({tag, ":aempty_r"}, 32'(ae_r), 32'(c <= AE_TH));
      chk({tag, ":afull_n"}, 32'(af_n), 32'(c >= AF_TH));
      chk({tag, ":afull_r"}, 32'(af_r), 32'(c >= AF_TH));
      chk({tag, ":ovf_n"},   32'(ovf_n), 32'(e_ovf));
      chk({tag, ":ovf_r"},   32'(ovf_r), 32'(e_ovf));
      chk({tag, ":unf_n"},   32'(unf_n), 32'(e_unf));
      chk({tag, ":unf_r"},   32'(unf_r), 32'(e_unf));
      chk({tag, ":qvalid_n"}, 32'(qv_n), 32'(e_qvn));
      chk({tag, ":qvalid_r"}, 32'(qv_r), 32'(e_qvr));
      chk({tag, ":q_n"},     32'(q_n), 32'(e_qn));
      chk({tag, ":q_r"},     32'(q_r), 32'(e_qr));
   endtask

   // One clock of stimulus; the model applies the FIFO rules to a queue.
   task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
      bit racc, wacc;
      logic [7:0] popped;
      @(negedge clk);
      wr = w; rd = r; data = d;
      racc = r && (fq.size() > 0);
      wacc = w && ((fq.size() < DEPTH) || racc);
      popped = 8'h00;
      if (racc) popped = fq.pop_front();
      if (wacc) fq.push_back(d);
      e_ovf = w && !wacc;
      e_unf = r && !racc;
      e_qvn = racc;
      if (racc) e_qn = popped;
      e_qvr = pend_v;
      if (pend_v) e_qr = pend_d;
      pend_v = racc;
      pend_d = popped;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      wr = 1'b0; rd = 1'b0; data = 8'h00;
      fq.delete();
      e_qn = 8'h00; e_qr = 8'h00; e_qvn = 1'b0; e_qvr = 1'b0;
      e_ovf = 1'b0; e_unf = 1'b0; pend_v = 1'b0; pend_d = 8'h00;
      #1;
      check_all({tag, ":async"});
      @(posedge clk);
      #1;
      check_all({tag, ":held"});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; wr = 1'b0; rd = 1'b0; data = 8'h00;
      #2;
      do_reset("por");

      for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 8'(i));
      step("overflow", 1'b1, 1'b0, 8'hEE);
      step("full_wr_rd", 1'b1, 1'b1, 8'hAA);
      for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00);
      step("underflow1", 1'b0, 1'b1, 8'h00);
      step("underflow2", 1'b0, 1'b1, 8'h00);
      step("idle", 1'b0, 1'b0, 8'h00);
      step("empty_wr_rd", 1'b1, 1'b1, 8'h55);
      step("read_55", 1'b0, 1'b1, 8'h00);
      step("idle", 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 4; i++) step("burst_wr", 1'b1, 1'b0, 8'(8'h30 + i));
      for (int i = 0; i < 4; i++) step("burst_rd", 1'b0, 1'b1, 8'h00);
      step("burst_tail1", 1'b0, 1'b0, 8'h00);
      step("burst_tail2", 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 8; i++) step("pre_rst_wr", 1'b1, 1'b0, 8'(8'h70 + i));
      step("pre_rst_rd", 1'b0, 1'b1, 8'h00);
      #1;
      do_reset("mid_rst");
      step("post_rst_idle1", 1'b0, 1'b0, 8'h00);
      step("post_rst_idle2", 1'b0, 1'b0, 8'h00);
      step("post_rst_wr", 1'b1, 1'b0, 8'hC3);
      step("post_rst_rd", 1'b0, 1'b1, 8'h00);
      step("post_rst_idle3", 1'b0, 1'b0, 8'h00);
      step("post_rst_idle4", 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = (((i / 100) % 2) == 0) ? 75 : 30;
         step("random",
              1'($urandom_range(0, 99) < wp),
              1'($urandom_range(0, 99) < (100 - wp)),
              8'($urandom));
      end
      step("final_idle", 1'b0, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
